fu_reservation_station: RTL and testbench
=========================================

# fu_reservation_station

Reservation station in front of a single functional unit (e.g. the logical FU). It accepts renamed instructions from dispatch and holds them until every source operand is available. It captures operand values from writeback broadcasts, then issues the oldest ready instruction onto the FU's `fu_if` input side whenever the FU reports ready.

## Interface
Parameters:
- `INST_ID_BITS`, 6, ROB instruction id width
- `PRN_BITS`, 6, physical register number width
- `MAX_OPERANDS`, 3, source operands / destination PRNs per instruction
- `DEPTH`, 4, entries (power of two, ≥2)
- `WB_PORTS`, 3, writeback broadcast ports

Ports:
- `clk` in 1: clock
- `rst` in 1: asynchronous, active-high reset
- `flush` in 1: synchronous squash of all entries and pending issue
- `disp_valid` in 1: dispatch request
- `disp_ready` out 1: at least one free entry
- `disp_inst_id` in `INST_ID_BITS`: ROB id
- `disp_inst` in 32: instruction word
- `disp_pc` in 64: PC
- `disp_src_prn` in `PRN_BITS`×`MAX_OPERANDS`: source PRNs
- `disp_src_rdy` in 1×`MAX_OPERANDS`: operand already available (unused operands are driven 1)
- `disp_src_data` in 64×`MAX_OPERANDS`: value when `disp_src_rdy` is set
- `disp_out_prn` in `PRN_BITS`×`MAX_OPERANDS`: destination PRNs, passed through unchanged
- `wb_valid` in 1×`WB_PORTS`: broadcast valid
- `wb_prn` in `PRN_BITS`×`WB_PORTS`: broadcast PRN
- `wb_data` in 64×`WB_PORTS`: broadcast value
- `iss_fu_ready` in 1: FU `fu_ready`
- `iss_inst_valid` out 1: FU `inst_valid`
- `iss_inst_id` out `INST_ID_BITS`: FU `inst_id`
- `iss_inst` out 32: FU `inst`
- `iss_op` out 64×`MAX_OPERANDS`: FU `op`
- `iss_out_prn` out `PRN_BITS`×`MAX_OPERANDS`: FU `out_prn`
- `iss_pc` out 64: FU `pc`

## Operation
- Each entry holds: valid, id, inst, pc, and per-operand {prn, rdy, data}, plus out_prn.
- Age is tracked with a `DEPTH`×`DEPTH` age matrix. On allocate, the new entry is marked younger than all valid entries.
- **Dispatch:** when `disp_valid && disp_ready`, the lowest-index free entry is written.
  - If a `disp_src_rdy` bit is 0 and a valid `wb_prn` matches that source in the same cycle, the operand is captured as ready with that `wb_data` (dispatch bypass).
- **Wakeup:** every valid, not-ready operand whose prn equals a valid `wb_prn` sets rdy and latches the data.
  - On multiple matches, the lowest port index wins.
  - PRN 0 has no special meaning.
- **Select:** candidates are valid entries whose operands are all rdy in the registered state. A same-cycle wakeup does not make an entry eligible.
  - When `iss_fu_ready` is 1 and a candidate exists, the oldest candidate is chosen. Its fields are registered onto `iss_*`, its valid bit is cleared, and its age row/column is cleared.
- `iss_inst_valid` is high for exactly one cycle per issued instruction. `iss_*` data holds its last value while `iss_inst_valid` is 0.
- `disp_ready` = OR of free bits from registered state. An entry freed by issue becomes allocatable the following cycle.
- `flush` clears all valid bits and `iss_inst_valid` at the next edge. It takes priority over dispatch, wakeup and select in that cycle.

## Timing
- **Reset** (async, immediate): all entries invalid, age matrix 0, `iss_inst_valid`=0, all `iss_*` data 0, `disp_ready`=1.
- **Minimum latency:** dispatch of a fully-ready instruction at edge N leads to `iss_inst_valid`=1 after edge N+1, provided `iss_fu_ready` is 1 in cycle N+1.
- **Wakeup latency:** broadcast sampled at edge N leads to the entry being eligible in cycle N+1 and issued after edge N+1.
- **Full:** with `DEPTH` valid entries, `disp_ready`=0 and `disp_valid` is ignored. The cycle of an issue from full still shows `disp_ready`=0.
- **Backpressure:** with `iss_fu_ready`=0, no selection occurs, `iss_inst_valid` falls to 0, and entries keep capturing wakeups.
- **Reset mid-operation** discards everything; no partial issue appears.

## Structure
- The shared package holds the `rs_entry_t` struct (operand sub-struct `rs_src_t`) parameterised on the `PRN_BITS`/`INST_ID_BITS` constants already used by `fu_if`.
- One sub-module, `rs_oldest_select`, contains the age matrix plus the ready mask and produces a one-hot grant and a valid signal.
- The top level contains the entry storage, wakeup/bypass compare, allocate priority encoder and issue registers. It connects directly to an `fu_if` instance in the FU wrapper.

## Test plan
- **Reset then ready dispatch:** dispatch id=5, all `disp_src_rdy`=1, op0=0xF0, `iss_fu_ready`=1 → `iss_inst_valid` one cycle later, `iss_inst_id`=5, `iss_op[0]`=0xF0.
- **Wakeup:** dispatch id=1 with src0 prn=12 not ready. Two cycles later broadcast prn=12, data=0xAA on port 2 → issue the cycle after the broadcast with `iss_op[0]`=0xAA.
- **Dispatch bypass:** dispatch src1 prn=7 not ready while `wb_prn[0]`=7 is valid with data 0x33 → issues next cycle with `iss_op[1]`=0x33.
- **Age order:** dispatch ids 2, 3, 4 waiting on prn 9, then broadcast prn 9 → issue order 2, 3, 4 on consecutive cycles.
- **Full and backpressure:** with `iss_fu_ready`=0, fill 4 entries → `disp_ready`=0 and a fifth dispatch is dropped. Raise ready → one issue per cycle, and `disp_ready`=1 in the cycle after the first issue.
- **Flush:** with 3 valid entries and an issue in flight, assert `flush` together with `disp_valid` → next cycle all empty, `iss_inst_valid`=0, `disp_ready`=1, nothing issues afterwards.

Source files
------------

// File: rtl/fu_reservation_station_pkg.sv
// Shared types for the reservation station: per-operand state and the full entry record.
// Widths track the PRN/ROB-id constants used by the FU interface.
package fu_reservation_station_pkg;

    localparam int unsigned RS_INST_ID_BITS = 6;
    localparam int unsigned RS_PRN_BITS     = 6;
    localparam int unsigned RS_MAX_OPERANDS = 3;

    typedef struct packed {
        logic [RS_PRN_BITS-1:0] prn;
        logic                   rdy;
        logic [63:0]            data;
    } rs_src_t;

    typedef struct packed {
        logic                                          valid;
        logic [RS_INST_ID_BITS-1:0]                    id;
        logic [31:0]                                   inst;
        logic [63:0]                                   pc;
        rs_src_t [RS_MAX_OPERANDS-1:0]                 src;
        logic [RS_MAX_OPERANDS-1:0][RS_PRN_BITS-1:0]   out_prn;
    } rs_entry_t;

endpackage

// File: rtl/rs_oldest_select.sv
// Age matrix plus oldest-ready picker: one-hot grant over the candidate entries.
// older_q[i][j] set means entry i was allocated before entry j.
module rs_oldest_select #(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [DEPTH-1:0] valid,
    input  logic [DEPTH-1:0] ready,
    input  logic [DEPTH-1:0] alloc,
    input  logic             sel_en,
    output logic [DEPTH-1:0] grant,
    output logic             grant_valid
);

    logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;
    logic [DEPTH-1:0]            cand;
    logic [DEPTH-1:0]            blocked;

    always_comb begin
        cand    = valid & ready;
        blocked = '0;
        grant   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            for (int j = 0; j < int'(DEPTH); j++) begin
                if (cand[j] && older_q[j][i]) blocked[i] = 1'b1;
            end
            grant[i] = sel_en && cand[i] && !blocked[i];
        end
        grant_valid = |grant;
    end

    // A new entry is younger than every entry that is still valid after this edge.
    always_comb begin
        older_d = older_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (grant[i]) begin
                for (int j = 0; j < int'(DEPTH); j++) begin
                    older_d[i][j] = 1'b0;
                    older_d[j][i] = 1'b0;
                end
            end
        end
        for (int n = 0; n < int'(DEPTH); n++) begin
            if (alloc[n]) begin
                for (int j = 0; j < int'(DEPTH); j++) begin
                    older_d[n][j] = 1'b0;
                    older_d[j][n] = valid[j] && !grant[j];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            older_q <= '0;
        end else if (flush) begin
            older_q <= '0;
        end else begin
            older_q <= older_d;
        end
    end

endmodule

// File: rtl/fu_reservation_station.sv
// Reservation station for one FU: holds dispatched ops until all sources are captured,
// then issues the oldest ready op into registered iss_* outputs.
module fu_reservation_station
    import fu_reservation_station_pkg::*;
#(
    parameter int unsigned INST_ID_BITS = RS_INST_ID_BITS,
    parameter int unsigned PRN_BITS     = RS_PRN_BITS,
    parameter int unsigned MAX_OPERANDS = RS_MAX_OPERANDS,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned WB_PORTS     = 3
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flush,
    input  logic                                    disp_valid,
    output logic                                    disp_ready,
    input  logic [INST_ID_BITS-1:0]                 disp_inst_id,
    input  logic [31:0]                             disp_inst,
    input  logic [63:0]                             disp_pc,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   disp_src_prn,
    input  logic [MAX_OPERANDS-1:0]                 disp_src_rdy,
    input  logic [MAX_OPERANDS-1:0][63:0]           disp_src_data,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   disp_out_prn,
    input  logic [WB_PORTS-1:0]                     wb_valid,
    input  logic [WB_PORTS-1:0][PRN_BITS-1:0]       wb_prn,
    input  logic [WB_PORTS-1:0][63:0]               wb_data,
    input  logic                                    iss_fu_ready,
    output logic                                    iss_inst_valid,
    output logic [INST_ID_BITS-1:0]                 iss_inst_id,
    output logic [31:0]                             iss_inst,
    output logic [MAX_OPERANDS-1:0][63:0]           iss_op,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   iss_out_prn,
    output logic [63:0]                             iss_pc
);

    rs_entry_t [DEPTH-1:0] entries_q, entries_d;
    rs_entry_t             new_entry, sel_entry;
    logic [DEPTH-1:0]      valid_vec, ready_vec, alloc, grant;
    logic                  grant_valid, sel_en, do_disp;

    always_comb begin
        valid_vec = '0;
        ready_vec = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            valid_vec[i] = entries_q[i].valid;
            ready_vec[i] = 1'b1;
            for (int k = 0; k < int'(MAX_OPERANDS); k++) begin
                ready_vec[i] = ready_vec[i] & entries_q[i].src[k].rdy;
            end
        end
    end

    assign disp_ready = ~&valid_vec;
    assign do_disp    = disp_valid && disp_ready && !flush;
    assign sel_en     = iss_fu_ready && !flush;

    // Lowest-index free entry; the descending scan leaves the lowest one set.
    always_comb begin
        alloc = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                alloc    = '0;
                alloc[i] = 1'b1;
            end
        end
        if (!do_disp) alloc = '0;
    end

    // Dispatch bypass: descending port scan so the lowest matching port wins.
    always_comb begin
        new_entry         = '0;
        new_entry.valid   = 1'b1;
        new_entry.id      = disp_inst_id;
        new_entry.inst    = disp_inst;
        new_entry.pc      = disp_pc;
        new_entry.out_prn = disp_out_prn;
        for (int k = 0; k < int'(MAX_OPERANDS); k++) begin
            new_entry.src[k].prn  = disp_src_prn[k];
            new_entry.src[k].rdy  = disp_src_rdy[k];
            new_entry.src[k].data = disp_src_data[k];
            if (!disp_src_rdy[k]) begin
                for (int p = int'(WB_PORTS) - 1; p >= 0; p--) begin
                    if (wb_valid[p] && wb_prn[p] == disp_src_prn[k]) begin
                        new_entry.src[k].rdy  = 1'b1;
                        new_entry.src[k].data = wb_data[p];
                    end
                end
            end
        end
    end

    always_comb begin
        entries_d = entries_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            for (int k = 0; k < int'(MAX_OPERANDS); k++) begin
                if (entries_q[i].valid && !entries_q[i].src[k].rdy) begin
                    for (int p = int'(WB_PORTS) - 1; p >= 0; p--) begin
                        if (wb_valid[p] && wb_prn[p] == entries_q[i].src[k].prn) begin
                            entries_d[i].src[k].rdy  = 1'b1;
                            entries_d[i].src[k].data = wb_data[p];
                        end
                    end
                end
            end
            if (grant[i]) entries_d[i].valid = 1'b0;
            if (alloc[i]) entries_d[i] = new_entry;
            if (flush)    entries_d[i].valid = 1'b0;
        end
    end

    always_comb begin
        sel_entry = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (grant[i]) sel_entry = entries_q[i];
        end
    end

    rs_oldest_select #(
        .DEPTH (DEPTH)
    ) u_select (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .valid       (valid_vec),
        .ready       (ready_vec),
        .alloc       (alloc),
        .sel_en      (sel_en),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries_q <= '0;
        end else begin
            entries_q <= entries_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_inst_valid <= 1'b0;
            iss_inst_id    <= '0;
            iss_inst       <= '0;
            iss_pc         <= '0;
            iss_op         <= '0;
            iss_out_prn    <= '0;
        end else begin
            iss_inst_valid <= grant_valid;
            if (grant_valid) begin
                iss_inst_id <= sel_entry.id;
                iss_inst    <= sel_entry.inst;
                iss_pc      <= sel_entry.pc;
                iss_out_prn <= sel_entry.out_prn;
                for (int k = 0; k < int'(MAX_OPERANDS); k++) begin
                    iss_op[k] <= sel_entry.src[k].data;
                end
            end
        end
    end

endmodule

// File: tb/tb_fu_reservation_station.sv
// Bench for fu_reservation_station: directed scenarios plus random traffic against an
// age-ordered queue model of the station.
module tb_fu_reservation_station;

    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst, flush, disp_valid, disp_ready, iss_fu_ready, iss_inst_valid;
    logic [5:0]       disp_inst_id, iss_inst_id;
    logic [31:0]      disp_inst, iss_inst;
    logic [63:0]      disp_pc, iss_pc;
    logic [2:0][5:0]  disp_src_prn, disp_out_prn, iss_out_prn, wb_prn;
    logic [2:0]       disp_src_rdy, wb_valid;
    logic [2:0][63:0] disp_src_data, wb_data, iss_op;

    always #5 clk = ~clk;

    fu_reservation_station dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .disp_valid     (disp_valid),
        .disp_ready     (disp_ready),
        .disp_inst_id   (disp_inst_id),
        .disp_inst      (disp_inst),
        .disp_pc        (disp_pc),
        .disp_src_prn   (disp_src_prn),
        .disp_src_rdy   (disp_src_rdy),
        .disp_src_data  (disp_src_data),
        .disp_out_prn   (disp_out_prn),
        .wb_valid       (wb_valid),
        .wb_prn         (wb_prn),
        .wb_data        (wb_data),
        .iss_fu_ready   (iss_fu_ready),
        .iss_inst_valid (iss_inst_valid),
        .iss_inst_id    (iss_inst_id),
        .iss_inst       (iss_inst),
        .iss_op         (iss_op),
        .iss_out_prn    (iss_out_prn),
        .iss_pc         (iss_pc)
    );

    typedef struct packed {
        logic [5:0]       id;
        logic [31:0]      inst;
        logic [63:0]      pc;
        logic [2:0]       rdy;
        logic [2:0][5:0]  prn;
        logic [2:0][63:0] data;
        logic [2:0][5:0]  outp;
    } m_entry_t;

    m_entry_t         q[$];
    logic             exp_valid;
    logic [5:0]       exp_id;
    logic [31:0]      exp_inst;
    logic [63:0]      exp_pc;
    logic [2:0][63:0] exp_op;
    logic [2:0][5:0]  exp_outp;
    int               n_vec = 0;
    int               n_err = 0;

    task automatic model_reset();
        q.delete();
        exp_valid = 1'b0;
        exp_id    = '0;
        exp_inst  = '0;
        exp_pc    = '0;
        exp_op    = '0;
        exp_outp  = '0;
    endtask

    task automatic idle();
        disp_valid    = 1'b0;
        disp_inst_id  = '0;
        disp_inst     = '0;
        disp_pc       = '0;
        disp_src_prn  = '0;
        disp_src_rdy  = '1;
        disp_src_data = '0;
        disp_out_prn  = '0;
        wb_valid      = '0;
        wb_prn        = '0;
        wb_data       = '0;
        flush         = 1'b0;
    endtask

    task automatic set_disp(input logic [5:0] id, input logic [63:0] op0);
        disp_valid       = 1'b1;
        disp_inst_id     = id;
        disp_inst        = 32'h1000_0000 | 32'(id);
        disp_pc          = 64'h8000_0000 + 64'(id) * 4;
        disp_src_rdy     = '1;
        disp_src_prn     = '0;
        disp_src_data    = '0;
        disp_src_data[0] = op0;
        disp_out_prn     = {6'd3, 6'd2, 6'd1};
    endtask

    // Fill in a not-ready operand from the lowest-numbered matching broadcast port.
    task automatic capture(inout m_entry_t e);
        bit hit;
        for (int k = 0; k < 3; k++) begin
            if (!e.rdy[k]) begin
                hit = 1'b0;
                for (int p = 0; p < 3; p++) begin
                    if (!hit && wb_valid[p] && wb_prn[p] == e.prn[k]) begin
                        hit       = 1'b1;
                        e.rdy[k]  = 1'b1;
                        e.data[k] = wb_data[p];
                    end
                end
            end
        end
    endtask

    // Advance model and DUT by one clock edge using the currently driven inputs.
    task automatic cycle();
        int       pre, sel;
        bit       found;
        m_entry_t e;
        pre   = q.size();
        found = 1'b0;
        sel   = 0;
        exp_valid = 1'b0;
        if (flush) begin
            q.delete();
        end else begin
            if (iss_fu_ready) begin
                for (int i = 0; i < q.size(); i++) begin
                    if (!found && q[i].rdy == 3'b111) begin
                        found = 1'b1;
                        sel   = i;
                    end
                end
            end
            if (found) begin
                e         = q[sel];
                exp_valid = 1'b1;
                exp_id    = e.id;
                exp_inst  = e.inst;
                exp_pc    = e.pc;
                exp_op    = e.data;
                exp_outp  = e.outp;
                q.delete(sel);
            end
            for (int i = 0; i < q.size(); i++) begin
                e = q[i];
                capture(e);
                q[i] = e;
            end
            if (disp_valid && pre < DEPTH) begin
                e.id   = disp_inst_id;
                e.inst = disp_inst;
                e.pc   = disp_pc;
                e.rdy  = disp_src_rdy;
                e.prn  = disp_src_prn;
                e.data = disp_src_data;
                e.outp = disp_out_prn;
                capture(e);
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        iss_fu_ready = 1'b1;
        #2;
        n_vec++;
        if (iss_inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got %b want 0", iss_inst_valid);
        end
        n_vec++;
        if (disp_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_disp_ready: got %b want 1", disp_ready);
        end
        n_vec++;
        if ({iss_inst_id, iss_inst, iss_pc, iss_op, iss_out_prn} !== '0) begin
            n_err++;
            $display("FAIL reset_iss_data: id %h inst %h pc %h not all zero", iss_inst_id,
                     iss_inst, iss_pc);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_ready_dispatch();
        iss_fu_ready = 1'b1;
        set_disp(6'd5, 64'hF0);
        cycle();
        idle();
        n_vec++;
        if (iss_inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ready_early: got valid %b want 0", iss_inst_valid);
        end
        cycle();
        n_vec++;
        if ({iss_inst_valid, iss_inst_id, iss_op[0]} !== {1'b1, 6'd5, 64'hF0}) begin
            n_err++;
            $display("FAIL ready_issue: got v=%b id=%0d op0=%h want v=1 id=5 op0=f0",
                     iss_inst_valid, iss_inst_id, iss_op[0]);
        end
        cycle();
    endtask

    task automatic test_wakeup();
        set_disp(6'd1, 64'h0);
        disp_src_rdy[0] = 1'b0;
        disp_src_prn[0] = 6'd12;
        cycle();
        idle();
        cycle();
        wb_valid[2] = 1'b1;
        wb_prn[2]   = 6'd12;
        wb_data[2]  = 64'hAA;
        cycle();
        idle();
        n_vec++;
        if (iss_inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wakeup_early: got valid %b want 0", iss_inst_valid);
        end
        cycle();
        n_vec++;
        if ({iss_inst_valid, iss_inst_id, iss_op[0]} !== {1'b1, 6'd1, 64'hAA}) begin
            n_err++;
            $display("FAIL wakeup_issue: got v=%b id=%0d op0=%h want v=1 id=1 op0=aa",
                     iss_inst_valid, iss_inst_id, iss_op[0]);
        end
        cycle();
    endtask

    task automatic test_bypass();
        set_disp(6'd6, 64'h0);
        disp_src_rdy[1] = 1'b0;
        disp_src_prn[1] = 6'd7;
        wb_valid   = 3'b101;
        wb_prn[0]  = 6'd7;
        wb_data[0] = 64'h33;
        wb_prn[2]  = 6'd7;
        wb_data[2] = 64'h99;
        cycle();
        idle();
        cycle();
        n_vec++;
        if ({iss_inst_valid, iss_inst_id, iss_op[1]} !== {1'b1, 6'd6, 64'h33}) begin
            n_err++;
            $display("FAIL bypass_issue: got v=%b id=%0d op1=%h want v=1 id=6 op1=33",
                     iss_inst_valid, iss_inst_id, iss_op[1]);
        end
        cycle();
    endtask

    task automatic test_age_order();
        for (int id = 2; id <= 4; id++) begin
            set_disp(6'(id), 64'h0);
            disp_src_rdy[0] = 1'b0;
            disp_src_prn[0] = 6'd9;
            cycle();
        end
        idle();
        wb_valid[1] = 1'b1;
        wb_prn[1]   = 6'd9;
        wb_data[1]  = 64'h99;
        cycle();
        idle();
        for (int id = 2; id <= 4; id++) begin
            cycle();
            n_vec++;
            if ({iss_inst_valid, iss_inst_id, iss_op[0]} !== {1'b1, 6'(id), 64'h99}) begin
                n_err++;
                $display("FAIL age_order: got v=%b id=%0d op0=%h want v=1 id=%0d op0=99",
                         iss_inst_valid, iss_inst_id, iss_op[0], id);
            end
        end
        cycle();
        n_vec++;
        if (iss_inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL age_drain: got valid %b want 0", iss_inst_valid);
        end
    endtask

    task automatic test_full_backpressure();
        iss_fu_ready = 1'b0;
        for (int id = 10; id <= 13; id++) begin
            set_disp(6'(id), 64'(id));
            cycle();
        end
        set_disp(6'd14, 64'd14);
        n_vec++;
        if (disp_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_ready: got %b want 0", disp_ready);
        end
        cycle();
        idle();
        n_vec++;
        if ({disp_ready, iss_inst_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL full_hold: got ready=%b valid=%b want 0 0", disp_ready,
                     iss_inst_valid);
        end
        iss_fu_ready = 1'b1;
        for (int id = 10; id <= 13; id++) begin
            cycle();
            n_vec++;
            if ({iss_inst_valid, iss_inst_id, disp_ready} !== {1'b1, 6'(id), 1'b1}) begin
                n_err++;
                $display("FAIL full_drain: got v=%b id=%0d rdy=%b want v=1 id=%0d rdy=1",
                         iss_inst_valid, iss_inst_id, disp_ready, id);
            end
        end
        cycle();
        n_vec++;
        if (iss_inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL full_dropped: got valid %b id=%0d want 0", iss_inst_valid,
                     iss_inst_id);
        end
    endtask

    task automatic test_flush();
        iss_fu_ready = 1'b0;
        for (int id = 20; id <= 23; id++) begin
            set_disp(6'(id), 64'(id));
            cycle();
        end
        idle();
        iss_fu_ready = 1'b1;
        cycle();
        n_vec++;
        if ({iss_inst_valid, iss_inst_id} !== {1'b1, 6'd20}) begin
            n_err++;
            $display("FAIL flush_pre: got v=%b id=%0d want v=1 id=20", iss_inst_valid,
                     iss_inst_id);
        end
        set_disp(6'd24, 64'd24);
        flush = 1'b1;
        cycle();
        idle();
        n_vec++;
        if ({iss_inst_valid, disp_ready, iss_inst_id} !== {1'b0, 1'b1, 6'd20}) begin
            n_err++;
            $display("FAIL flush_clear: got v=%b rdy=%b id=%0d want v=0 rdy=1 id=20",
                     iss_inst_valid, disp_ready, iss_inst_id);
        end
        for (int c = 0; c < 3; c++) begin
            cycle();
            n_vec++;
            if (iss_inst_valid !== 1'b0) begin
                n_err++;
                $display("FAIL flush_after: got valid %b id=%0d want 0", iss_inst_valid,
                         iss_inst_id);
            end
        end
    endtask

    task automatic test_reset_mid();
        iss_fu_ready = 1'b0;
        set_disp(6'd30, 64'd30);
        cycle();
        set_disp(6'd31, 64'd31);
        cycle();
        idle();
        iss_fu_ready = 1'b1;
        cycle();
        rst = 1'b1;
        #1;
        n_vec++;
        if ({iss_inst_valid, disp_ready, iss_inst_id} !== {1'b0, 1'b1, 6'd0}) begin
            n_err++;
            $display("FAIL reset_mid: got v=%b rdy=%b id=%0d want v=0 rdy=1 id=0",
                     iss_inst_valid, disp_ready, iss_inst_id);
        end
        #1;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 2; c++) begin
            cycle();
            n_vec++;
            if (iss_inst_valid !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid_after: got valid %b id=%0d want 0", iss_inst_valid,
                         iss_inst_id);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            disp_valid   = 1'($urandom_range(0, 1));
            disp_inst_id = 6'($urandom);
            disp_inst    = $urandom;
            disp_pc      = {$urandom, $urandom};
            for (int k = 0; k < 3; k++) begin
                disp_src_prn[k]  = 6'($urandom_range(0, 7));
                disp_src_rdy[k]  = ($urandom_range(0, 2) != 0);
                disp_src_data[k] = {$urandom, $urandom};
                disp_out_prn[k]  = 6'($urandom);
                wb_valid[k]      = ($urandom_range(0, 2) == 0);
                wb_prn[k]        = 6'($urandom_range(0, 7));
                wb_data[k]       = {$urandom, $urandom};
            end
            flush        = ($urandom_range(0, 39) == 0);
            iss_fu_ready = ($urandom_range(0, 3) != 0);
            cycle();
            n_vec++;
            if (iss_inst_valid !== exp_valid) begin
                n_err++;
                $display("FAIL rand_valid cyc %0d: got %b want %b", c, iss_inst_valid,
                         exp_valid);
            end
            n_vec++;
            if ({iss_inst_id, iss_inst, iss_pc, iss_op, iss_out_prn} !==
                {exp_id, exp_inst, exp_pc, exp_op, exp_outp}) begin
                n_err++;
                $display("FAIL rand_data cyc %0d: got id=%0d pc=%h op0=%h want id=%0d pc=%h op0=%h",
                         c, iss_inst_id, iss_pc, iss_op[0], exp_id, exp_pc, exp_op[0]);
            end
            n_vec++;
            if (disp_ready !== (q.size() < DEPTH)) begin
                n_err++;
                $display("FAIL rand_disp_ready cyc %0d: got %b want %b", c, disp_ready,
                         q.size() < DEPTH);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_ready_dispatch();
        test_wakeup();
        test_bypass();
        test_age_order();
        test_full_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
